// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral that fills a bank of NUM_REGS config registers from
// length-checked write frames. Define SPI_READBACK_EN to return register data on cipo for read frames.
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]  NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [2:0]            ncs_sync_q, ncs_sync_d;
    logic [1:0]            copi_sync_q, copi_sync_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic                  wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic                  frame_err_q, frame_err_d;

    logic                  sclk_rise;
    logic                  ncs_low;
    logic                  ncs_rise;
    logic                  frame_wr;
    logic [ADDR_W-1:0]     frame_addr;
    logic [DATA_W-1:0]     frame_data;
    logic                  addr_ok;
    logic                  commit_wr;

    // Stages [1:0] synchronise; stage [2] is only the edge-detect delay.
    assign sclk_sync_d = {sclk_sync_q[1:0], sclk};
    assign ncs_sync_d  = {ncs_sync_q[1:0], ncs};
    assign copi_sync_d = {copi_sync_q[0], copi};

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ncs_low   = ~ncs_sync_q[1];
    assign ncs_rise  = ncs_sync_q[1] & ~ncs_sync_q[2];

    assign frame_wr   = shift_q[FRAME_W-1];
    assign frame_addr = shift_q[DATA_W +: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];
    assign addr_ok    = ({1'b0, frame_addr} < NUM_REGS_W);
    assign commit_wr  = (state_q == ST_COMMIT) && (cnt_q == CNT_FULL) && frame_wr && addr_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        wr_stb_d    = commit_wr;
        wr_addr_d   = commit_wr ? frame_addr : wr_addr_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Level test, so a chip select that fell during COMMIT is still taken here.
                if (ncs_low) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise && ncs_low) begin
                    shift_d = {shift_q[FRAME_W-2:0], copi_sync_q[1]};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cnt_q != CNT_FULL) begin
                    frame_err_d = 1'b1;
                end else if (frame_wr && !addr_ok) begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign regs_d[gi] = (commit_wr && (frame_addr == ADDR_W'(gi))) ? frame_data : regs_q[gi];
            assign regs_o[gi*DATA_W +: DATA_W] = regs_q[gi];
        end
    endgenerate

`ifdef SPI_READBACK_EN
    localparam int TXC_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [TXC_W-1:0]  tx_left_q, tx_left_d;
    logic              cipo_q, cipo_d;
    logic              sclk_fall;
    logic              tx_load;
    logic [DATA_W-1:0] rd_val;

    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    // Load on the edge that completes R/W plus address; shift_d already holds that bit.
    assign tx_load = (state_q == ST_SHIFT) && ncs_low && sclk_rise && !ncs_rise
                     && (cnt_q == CNT_W'(ADDR_W)) && !shift_d[ADDR_W];

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (shift_d[ADDR_W-1:0] == ADDR_W'(k)) begin
                rd_val = regs_q[k];
            end
        end
    end

    always_comb begin
        tx_d      = tx_q;
        tx_left_d = tx_left_q;
        cipo_d    = cipo_q;
        if ((state_q != ST_SHIFT) || !ncs_low) begin
            tx_left_d = '0;
            cipo_d    = 1'b0;
        end else if (tx_load) begin
            tx_d      = rd_val;
            tx_left_d = TXC_W'(DATA_W);
        end else if (sclk_fall) begin
            if (tx_left_q != '0) begin
                cipo_d    = tx_q[DATA_W-1];
                tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                tx_left_d = tx_left_q - 1'b1;
            end else begin
                cipo_d = 1'b0;
            end
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= 3'b000;
            ncs_sync_q  <= 3'b111;
            copi_sync_q <= 2'b00;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
`ifdef SPI_READBACK_EN
            tx_q        <= '0;
            tx_left_q   <= '0;
            cipo_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            copi_sync_q <= copi_sync_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
`ifdef SPI_READBACK_EN
            tx_q        <= tx_d;
            tx_left_q   <= tx_left_d;
            cipo_q      <= cipo_d;
`endif
        end
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: SPI frames driven at 1/8 of clk, pulses counted per clock.
module tb_spi_reg_bank;
    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       sclk = 1'b0;
    logic                       copi = 1'b0;
    logic                       ncs = 1'b1;
    logic                       cipo;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic                       wr_stb;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .regs_o(regs_o), .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Each clock a pulse is high counts once, so a 1-clk pulse adds exactly 1.
    always @(posedge clk) begin
        if (wr_stb === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr;
        end
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
        end
    end

    task automatic spi_bit(input logic b, output logic rx);
        copi = b;
        #40;
        rx = cipo;
        sclk = 1'b1;
        #40;
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int n, input int gap, output logic [31:0] rx);
        logic r;
        rx = '0;
        ncs = 1'b0;
        #40;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(bits[i], r);
            rx = {rx[30:0], r};
        end
        #40;
        ncs = 1'b1;
        #(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #33;
        vectors++;
        if (regs_o !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_regs got=%h exp=%h", regs_o, 40'h0);
        end
        vectors++;
        if ({wr_stb, frame_err, cipo} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=000", {wr_stb, frame_err, cipo});
        end
        vectors++;
        if (wr_addr !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #50;
        $display("reset: regs=%h", regs_o);
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        logic [31:0] rx;
        spi_frame(32'h8355, 16, 200, rx);
        $display("write 0x8355: regs=%h wr=%0d err=%0d addr=%0d", regs_o, wr_cnt - w0, err_cnt - e0, last_addr);
        vectors++;
        if (regs_o !== 40'h00_55_00_00_00) begin
            miscompares++;
            $display("FAIL write_regs got=%h exp=%h", regs_o, 40'h00_55_00_00_00);
        end
        vectors++;
        if (wr_cnt - w0 !== 1) begin
            miscompares++;
            $display("FAIL write_stb_cycles got=%0d exp=1", wr_cnt - w0);
        end
        vectors++;
        if (last_addr !== 7'd3) begin
            miscompares++;
            $display("FAIL write_addr got=%0d exp=3", last_addr);
        end
        vectors++;
        if (err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL write_err got=%0d exp=0", err_cnt - e0);
        end
    endtask

    task automatic test_bad_addr();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        logic [31:0] rx;
        spi_frame(32'h85AA, 16, 200, rx);
        $display("write 0x85AA: regs=%h wr=%0d err=%0d", regs_o, wr_cnt - w0, err_cnt - e0);
        vectors++;
        if (regs_o !== 40'h00_55_00_00_00) begin
            miscompares++;
            $display("FAIL badaddr_regs got=%h exp=%h", regs_o, 40'h00_55_00_00_00);
        end
        vectors++;
        if (wr_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL badaddr_stb got=%0d exp=0", wr_cnt - w0);
        end
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL badaddr_err got=%0d exp=1", err_cnt - e0);
        end
    endtask

    task automatic test_bad_length();
        int w0 = wr_cnt;
        int e0;
        logic [31:0] rx;
        e0 = err_cnt;
        spi_frame(32'h20D, 10, 200, rx);
        $display("10-bit frame: err=%0d", err_cnt - e0);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL short_err got=%0d exp=1", err_cnt - e0);
        end
        e0 = err_cnt;
        spi_frame(32'h10600, 17, 200, rx);
        $display("17-bit frame: err=%0d", err_cnt - e0);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL long_err got=%0d exp=1", err_cnt - e0);
        end
        e0 = err_cnt;
        spi_frame(32'h0, 0, 200, rx);
        $display("0-bit frame: err=%0d", err_cnt - e0);
        vectors++;
        if (err_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL empty_err got=%0d exp=1", err_cnt - e0);
        end
        vectors++;
        if (regs_o !== 40'h00_55_00_00_00 || wr_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL badlen_regs got=%h/%0d exp=%h/0", regs_o, wr_cnt - w0, 40'h00_55_00_00_00);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        logic [31:0] rx;
        spi_frame(32'h8011, 16, 80, rx);
        spi_frame(32'h8122, 16, 80, rx);
        spi_frame(32'h8433, 16, 200, rx);
        $display("b2b 0x8011/0x8122/0x8433: regs=%h wr=%0d err=%0d", regs_o, wr_cnt - w0, err_cnt - e0);
        vectors++;
        if (regs_o !== 40'h33_55_00_22_11) begin
            miscompares++;
            $display("FAIL b2b_regs got=%h exp=%h", regs_o, 40'h33_55_00_22_11);
        end
        vectors++;
        if (wr_cnt - w0 !== 3) begin
            miscompares++;
            $display("FAIL b2b_stb got=%0d exp=3", wr_cnt - w0);
        end
        vectors++;
        if (err_cnt - e0 !== 0 || last_addr !== 7'd4) begin
            miscompares++;
            $display("FAIL b2b_err_addr got=%0d/%0d exp=0/4", err_cnt - e0, last_addr);
        end
    endtask

    task automatic test_readback();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        logic [31:0] rx;
        logic [7:0] exp_rd;
`ifdef SPI_READBACK_EN
        exp_rd = 8'hA5;
`else
        exp_rd = 8'h00;
`endif
        spi_frame(32'h81A5, 16, 200, rx);
        spi_frame(32'h0100, 16, 200, rx);
        $display("write 0x81A5, read 0x0100: data=%h regs=%h", rx[7:0], regs_o);
        vectors++;
        if (rx[7:0] !== exp_rd) begin
            miscompares++;
            $display("FAIL read_data got=%h exp=%h", rx[7:0], exp_rd);
        end
        vectors++;
        if (regs_o !== 40'h33_55_00_A5_11) begin
            miscompares++;
            $display("FAIL read_regs got=%h exp=%h", regs_o, 40'h33_55_00_A5_11);
        end
        vectors++;
        if (wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL read_pulses got=%0d/%0d exp=1/0", wr_cnt - w0, err_cnt - e0);
        end
        vectors++;
        if (cipo !== 1'b0) begin
            miscompares++;
            $display("FAIL read_cipo_idle got=%b exp=0", cipo);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic r;
        logic [31:0] rx;
        int e0;
        ncs = 1'b0;
        #40;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(1'(8'h82 >> i), r);
        end
        rst_n = 1'b0;
        #20;
        ncs = 1'b1;
        #30;
        vectors++;
        if (regs_o !== 40'h0) begin
            miscompares++;
            $display("FAIL midrst_regs got=%h exp=%h", regs_o, 40'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e0 = err_cnt;
        #100;
        vectors++;
        if (regs_o !== 40'h0 || err_cnt - e0 !== 0) begin
            miscompares++;
            $display("FAIL midrst_after got=%h/%0d exp=%h/0", regs_o, err_cnt - e0, 40'h0);
        end
        spi_frame(32'h82FF, 16, 200, rx);
        $display("after reset, write 0x82FF: regs=%h addr=%0d", regs_o, last_addr);
        vectors++;
        if (regs_o !== 40'h00_00_FF_00_00 || last_addr !== 7'd2) begin
            miscompares++;
            $display("FAIL midrst_write got=%h/%0d exp=%h/2", regs_o, last_addr, 40'h00_00_FF_00_00);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_bad_length();
        test_back_to_back();
        test_readback();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
